// File: rtl/gates_pipe_pkg.sv
// Shared mode encodings and default sizes for the gates_pipe lane datapath.
package gates_pipe_pkg;

    typedef enum logic [1:0] {
        MODE_ANDOR   = 2'b00,
        MODE_NANDNOR = 2'b01,
        MODE_XOR     = 2'b10,
        MODE_PASS    = 2'b11
    } mode_e;

    localparam int DEFAULT_WIDTH    = 8;
    localparam int DEFAULT_CHANNELS = 4;
    localparam int DEFAULT_CNT_W    = 16;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

endpackage

// File: rtl/gates_pipe_if.sv
// Input/output handshake bundle for gates_pipe; GATES_PIPE_PARITY_EN adds the per-lane out_par signal.
interface gates_pipe_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic [CHANNELS*WIDTH-1:0] in_a;
    logic [CHANNELS*WIDTH-1:0] in_b;
    logic [2*CHANNELS-1:0]     in_mode;
    logic                      out_valid;
    logic                      out_ready;
    logic [CHANNELS*WIDTH-1:0] out1;
    logic [CHANNELS*WIDTH-1:0] out2;
    logic [CNT_W-1:0]          xfer_cnt;
`ifdef GATES_PIPE_PARITY_EN
    logic [CHANNELS-1:0]       out_par;

    modport master (
        output in_valid, in_a, in_b, in_mode, out_ready,
        input  in_ready, out_valid, out1, out2, xfer_cnt, out_par
    );

    modport slave (
        input  in_valid, in_a, in_b, in_mode, out_ready,
        output in_ready, out_valid, out1, out2, xfer_cnt, out_par
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_mode, out_ready,
        input  in_ready, out_valid, out1, out2, xfer_cnt
    );

    modport slave (
        input  in_valid, in_a, in_b, in_mode, out_ready,
        output in_ready, out_valid, out1, out2, xfer_cnt
    );
`endif

endinterface

// File: rtl/gates_pipe_op.sv
// Single-lane combinational gate pair: mode selects which complementary pair drives out1/out2.
module gates_pipe_op
    import gates_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)(
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_out1,
    output logic [WIDTH-1:0] o_out2
);

    always_comb begin
        o_out1 = i_a;
        o_out2 = i_b;
        case (i_mode)
            MODE_ANDOR: begin
                o_out1 = i_a & i_b;
                o_out2 = i_a | i_b;
            end
            MODE_NANDNOR: begin
                o_out1 = ~(i_a & i_b);
                o_out2 = ~(i_a | i_b);
            end
            MODE_XOR: begin
                o_out1 = i_a ^ i_b;
                o_out2 = ~(i_a ^ i_b);
            end
            default: begin
                o_out1 = i_a;
                o_out2 = i_b;
            end
        endcase
    end

endmodule

// File: rtl/gates_pipe.sv
// Multi-lane gate-pair pipeline with a 2-entry valid/ready output buffer and saturating transfer counter.
// Optional macro GATES_PIPE_PARITY_EN stores and outputs even parity of each lane's out1.
module gates_pipe
    import gates_pipe_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int CHANNELS = DEFAULT_CHANNELS,
    parameter int CNT_W    = DEFAULT_CNT_W
)(
    input  logic        clk,
    input  logic        rstn,
    gates_pipe_if.slave bus
);

    localparam int DATA_W = CHANNELS * WIDTH;

    logic [DATA_W-1:0] w_out1;
    logic [DATA_W-1:0] w_out2;
    logic              w_push;
    logic              w_pop;
    logic [1:0]        w_occNext;

    logic [1:0]        r_occ;
    logic              r_inReady;
    logic [DATA_W-1:0] r_headOut1;
    logic [DATA_W-1:0] r_headOut2;
    logic [DATA_W-1:0] r_tailOut1;
    logic [DATA_W-1:0] r_tailOut2;
    logic [CNT_W-1:0]  r_xferCnt;

`ifdef GATES_PIPE_PARITY_EN
    logic [CHANNELS-1:0] w_par;
    logic [CHANNELS-1:0] r_headPar;
    logic [CHANNELS-1:0] r_tailPar;
`endif

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        gates_pipe_op #(.WIDTH(WIDTH)) u_op (
            .i_mode (bus.in_mode[2*k +: 2]),
            .i_a    (bus.in_a[k*WIDTH +: WIDTH]),
            .i_b    (bus.in_b[k*WIDTH +: WIDTH]),
            .o_out1 (w_out1[k*WIDTH +: WIDTH]),
            .o_out2 (w_out2[k*WIDTH +: WIDTH])
        );
`ifdef GATES_PIPE_PARITY_EN
        assign w_par[k] = ^w_out1[k*WIDTH +: WIDTH];
`endif
    end

    assign w_push = bus.in_valid & r_inReady;
    assign w_pop  = (r_occ != OCC_EMPTY) & bus.out_ready;

    always_comb begin
        w_occNext = r_occ;
        if (w_push && !w_pop) begin
            w_occNext = r_occ + 2'd1;
        end else if (!w_push && w_pop) begin
            w_occNext = r_occ - 2'd1;
        end
    end

    // The head register doubles as the output register, so out1/out2 hold their value while empty.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_occ      <= OCC_EMPTY;
            r_inReady  <= 1'b1;
            r_headOut1 <= '0;
            r_headOut2 <= '0;
            r_tailOut1 <= '0;
            r_tailOut2 <= '0;
`ifdef GATES_PIPE_PARITY_EN
            r_headPar  <= '0;
            r_tailPar  <= '0;
`endif
        end else begin
            r_occ     <= w_occNext;
            r_inReady <= (w_occNext != OCC_FULL);
            if (w_push && ((r_occ == OCC_EMPTY) || ((r_occ == OCC_ONE) && w_pop))) begin
                r_headOut1 <= w_out1;
                r_headOut2 <= w_out2;
`ifdef GATES_PIPE_PARITY_EN
                r_headPar  <= w_par;
`endif
            end else if (w_pop && (r_occ == OCC_FULL)) begin
                r_headOut1 <= r_tailOut1;
                r_headOut2 <= r_tailOut2;
`ifdef GATES_PIPE_PARITY_EN
                r_headPar  <= r_tailPar;
`endif
            end
            if (w_push && (r_occ == OCC_ONE) && !w_pop) begin
                r_tailOut1 <= w_out1;
                r_tailOut2 <= w_out2;
`ifdef GATES_PIPE_PARITY_EN
                r_tailPar  <= w_par;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_xferCnt <= '0;
        end else if (w_pop && (r_xferCnt != {CNT_W{1'b1}})) begin
            r_xferCnt <= r_xferCnt + CNT_W'(1);
        end
    end

    // in_ready is registered but must read low for the whole time reset is held.
    assign bus.in_ready  = r_inReady & rstn;
    assign bus.out_valid = (r_occ != OCC_EMPTY);
    assign bus.out1      = r_headOut1;
    assign bus.out2      = r_headOut2;
    assign bus.xfer_cnt  = r_xferCnt;
`ifdef GATES_PIPE_PARITY_EN
    assign bus.out_par   = r_headPar;
`endif

endmodule
